// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - SHA-256 message padder: byte stream in, padded 512-bit blocks out
module sha256_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last
);

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_OUT,
        S_LEN
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       ptr_q, ptr_d;
    logic [LEN_W-1:0] bitlen_q, bitlen_d;
    logic             first_pend_q, first_pend_d;
    logic             need_len_q, need_len_d;
    logic             pad0_q, pad0_d;
    logic [511:0]     blk_data_q, blk_data_d;
    logic             blk_valid_q, blk_valid_d;
    logic             blk_first_q, blk_first_d;
    logic             blk_last_q, blk_last_d;
    logic [63:0]      len_field;

    assign len_field = 64'(bitlen_q);

    assign in_ready  = (state_q == S_FILL);
    assign blk_data  = blk_data_q;
    assign blk_valid = blk_valid_q;
    assign blk_first = blk_first_q;
    assign blk_last  = blk_last_q;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        bitlen_d     = bitlen_q;
        first_pend_d = first_pend_q;
        need_len_d   = need_len_q;
        pad0_d       = pad0_q;
        blk_data_d   = blk_data_q;
        blk_valid_d  = blk_valid_q;
        blk_first_d  = blk_first_q;
        blk_last_d   = blk_last_q;
        case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    // Byte k of the block lives at bits [8*(63-k) +: 8]; 63-k is ~k in 6 bits.
                    blk_data_d[{~ptr_q, 3'b000} +: 8] = in_data;
                    ptr_d    = ptr_q + 6'd1;
                    bitlen_d = bitlen_q + LEN_W'(8);
                    if (ptr_q == 6'd63) begin
                        state_d     = S_OUT;
                        pad0_d      = in_last;
                        blk_valid_d = 1'b1;
                        blk_first_d = first_pend_q;
                        blk_last_d  = 1'b0;
                    end else if (in_last) begin
                        state_d = S_PAD;
                    end
                end
            end
            S_PAD: begin
                blk_data_d[{~ptr_q, 3'b000} +: 8] = 8'h80;
                state_d     = S_OUT;
                blk_valid_d = 1'b1;
                blk_first_d = first_pend_q;
                if (ptr_q <= 6'd55) begin
                    blk_data_d[63:0] = len_field;
                    blk_last_d       = 1'b1;
                end else begin
                    need_len_d = 1'b1;
                    blk_last_d = 1'b0;
                end
            end
            S_OUT: begin
                if (blk_ready) begin
                    blk_valid_d  = 1'b0;
                    blk_first_d  = 1'b0;
                    blk_last_d   = 1'b0;
                    first_pend_d = 1'b0;
                    if (blk_last_q) begin
                        bitlen_d     = '0;
                        first_pend_d = 1'b1;
                    end
                    if (pad0_q || need_len_q) begin
                        state_d = S_LEN;
                    end else begin
                        state_d    = S_FILL;
                        ptr_d      = '0;
                        blk_data_d = '0;
                    end
                end
            end
            S_LEN: begin
                blk_data_d          = '0;
                blk_data_d[511:504] = pad0_q ? 8'h80 : 8'h00;
                blk_data_d[63:0]    = len_field;
                pad0_d              = 1'b0;
                need_len_d          = 1'b0;
                state_d             = S_OUT;
                blk_valid_d         = 1'b1;
                blk_first_d         = first_pend_q;
                blk_last_d          = 1'b1;
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FILL;
            ptr_q        <= '0;
            bitlen_q     <= '0;
            first_pend_q <= 1'b1;
            need_len_q   <= 1'b0;
            pad0_q       <= 1'b0;
            blk_data_q   <= '0;
            blk_valid_q  <= 1'b0;
            blk_first_q  <= 1'b0;
            blk_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            bitlen_q     <= bitlen_d;
            first_pend_q <= first_pend_d;
            need_len_q   <= need_len_d;
            pad0_q       <= pad0_d;
            blk_data_q   <= blk_data_d;
            blk_valid_q  <= blk_valid_d;
            blk_first_q  <= blk_first_d;
            blk_last_q   <= blk_last_d;
        end
    end

endmodule
